pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Fetch-side PC owner and branch redirect controller. It consumes the taken-branch decision and target produced by the EX-stage branch logic, and steers the program counter. It also generates registered flush pulses for the IF/ID and ID/EX pipeline registers and honours stalls from hazard detection. It sits between the branch decision logic in EX and the instruction-fetch stage.

## Interface
- `ADDR_W`, 64: PC and target width in bits.
- `RESET_PC`, 0: PC value loaded on reset.
- `FLUSH_CYCLES`, 2: cycles the flush outputs stay high after a redirect; legal range 1..7.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `stall`  input  1  load-use stall from hazard detection; holds the PC.
- `branch`  input  1  a branch instruction is resolving in EX this cycle.
- `to_branch`  input  1  the resolving branch is taken.
- `branch_target`  input  ADDR_W  target address computed in EX.
- `pc_out`  output  ADDR_W  current fetch PC (registered).
- `pc_plus4`  output  ADDR_W  `pc_out + 4`, combinational, modulo 2^ADDR_W.
- `if_id_flush`  output  1  registered flush of the IF/ID register.
- `id_ex_flush`  output  1  registered flush of the ID/EX register.
- `redirect_busy`  output  1  high while the unit is in FLUSH.
- `misaligned`  output  1  registered one-cycle pulse: the accepted target had bit 1 or bit 0 set.

## Operation
- The unit has two states, RUN and FLUSH, plus a 3-bit down-counter `fcnt`.
- Reset asserted (low) has immediate effect:
  - `pc_out`=RESET_PC, state=RUN, `fcnt`=0.
  - `if_id_flush`, `id_ex_flush`, `redirect_busy` and `misaligned` are 0.
- RUN, with `to_branch` && `branch`:
  - Redirect accepted at the next edge: `pc_out` <= {branch_target[ADDR_W-1:2], 2'b00}.
  - State goes to FLUSH and `fcnt` <= FLUSH_CYCLES-1.
  - Both flush outputs go to 1.
  - `misaligned` <= |branch_target[1:0].
- `to_branch` without `branch` is ignored and treated as not taken.
- RUN, no redirect, `stall`=1: `pc_out` holds and the flush outputs stay 0.
- RUN, no redirect, `stall`=0: `pc_out` <= `pc_plus4`.
- Priority is redirect > stall. A taken branch in a stall cycle still redirects.
- FLUSH:
  - Flush outputs and `redirect_busy` stay 1.
  - `to_branch` is ignored, because a wrong-path instruction cannot be a valid branch.
  - `pc_out` advances by 4 per cycle unless `stall`=1, in which case it holds.
  - `fcnt` decrements every cycle regardless of `stall`.
  - When `fcnt`==0 at an edge: state <= RUN and the flush outputs <= 0.
- `misaligned` is high for exactly one cycle per offending redirect.
- PC arithmetic wraps: all-ones minus 3, plus 4, gives 0. No overflow flag.

## Timing
- Redirect latency is one cycle. With `to_branch` high in cycle N, `pc_out` equals the target in cycle N+1.
- Flush outputs are high in cycles N+1 .. N+FLUSH_CYCLES inclusive, then low.
- `redirect_busy` equals the flush outputs cycle for cycle.
- The earliest next accepted redirect is in cycle N+FLUSH_CYCLES+1.
- `pc_plus4` follows `pc_out` in the same cycle, with no register.
- Reset mid-FLUSH aborts at once: all outputs return to reset values, with no residual flush.
- After reset deassertion, the first edge with `stall`=0 gives `pc_out`=RESET_PC+4.

## Configuration
- `BRANCH_STATS_EN` defined:
  - Adds output `taken_count` [31:0] and output `resolved_count` [31:0].
  - Both reset to 0.
  - `resolved_count` increments on every cycle with `branch`=1 in RUN.
  - `taken_count` increments on every accepted redirect.
  - Both saturate at 32'hFFFF_FFFF.
- `BRANCH_STATS_EN` not defined:
  - Neither port exists and no counter logic is built.
  - All other behaviour is identical.

## Test plan
- Reset, then 5 cycles with `stall`=0 -> `pc_out` reads 0,4,8,12,16; flush outputs stay 0.
- `pc_out`=0x10, assert `branch`=`to_branch`=1 with target 0x100 for one cycle -> next cycle `pc_out`=0x100; `if_id_flush`/`id_ex_flush` high for exactly 2 cycles; `pc_out` 0x104 while flushing.
- `stall`=1 and taken branch in the same cycle, target 0x200 -> redirect wins, `pc_out`=0x200 the next cycle. Then `stall`=1 during FLUSH -> `pc_out` holds 0x200 and the flush still ends after 2 cycles.
- Second taken branch during FLUSH, target 0x300 -> ignored, `pc_out` continues from the first target; a taken branch in the first RUN cycle after FLUSH is accepted.
- Target 0x402 -> `pc_out`=0x400 and `misaligned` pulses for 1 cycle. Reset asserted in the first FLUSH cycle -> flushes drop to 0 immediately and `pc_out`=RESET_PC.
- With `BRANCH_STATS_EN`: 3 resolved branches, 1 taken -> `resolved_count`=3, `taken_count`=1.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch-side PC owner and taken-branch redirect controller.
// Owns the fetch PC. Applies taken-branch redirects from EX and raises registered
// IF/ID and ID/EX flushes for FLUSH_CYCLES cycles. Honours load-use stalls.
// Optional feature macro: BRANCH_STATS_EN adds the taken_count and resolved_count counters.
module pc_redirect_unit #(
  parameter int                 ADDR_W       = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter int                 FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              to_branch,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              redirect_busy,
  output logic              misaligned
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       taken_count,
  output logic [31:0]       resolved_count
`endif
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state, state_nx;
  logic [2:0]        fcnt, fcnt_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic              flush_q, flush_nx;
  logic              mis_nx;

  assign pc_plus4      = pc_out + ADDR_W'(4);
  assign if_id_flush   = flush_q;
  assign id_ex_flush   = flush_q;
  assign redirect_busy = flush_q;

  // State, PC and flush register. Reset aborts any flush immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      fcnt       <= '0;
      pc_out     <= RESET_PC;
      flush_q    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_nx;
      fcnt       <= fcnt_nx;
      pc_out     <= pc_nx;
      flush_q    <= flush_nx;
      misaligned <= mis_nx;
    end
  end

  // Next-state logic. In RUN, a redirect has priority over a stall.
  // In FLUSH, to_branch is ignored because any branch seen then is on the wrong path.
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    pc_nx    = pc_out;
    mis_nx   = 1'b0;
    flush_nx = 1'b0;
    case (state)
      RUN: begin
        if (branch && to_branch) begin
          pc_nx    = {branch_target[ADDR_W-1:2], 2'b00};
          state_nx = FLUSH;
          fcnt_nx  = 3'(FLUSH_CYCLES - 1);
          flush_nx = 1'b1;
          mis_nx   = |branch_target[1:0];
        end else if (!stall) begin
          pc_nx = pc_plus4;
        end
      end
      FLUSH: begin
        if (!stall) pc_nx = pc_plus4;
        // fcnt counts down every cycle, stalled or not.
        if (fcnt == 3'd0) begin
          state_nx = RUN;
        end else begin
          fcnt_nx  = fcnt - 3'd1;
          flush_nx = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

`ifdef BRANCH_STATS_EN
  // Saturating counters: every branch resolved in RUN, and every accepted redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_count    <= '0;
      resolved_count <= '0;
    end else if (state == RUN && branch) begin
      if (resolved_count != 32'hFFFF_FFFF) resolved_count <= resolved_count + 32'd1;
      if (to_branch && taken_count != 32'hFFFF_FFFF) taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit. A reference model predicts the outputs at
// every clock edge and pushes them into a queue. The expected values are popped
// and compared 1 time unit after the edge.
module tb_pc_redirect_unit;
  localparam int          AW  = 64;
  localparam logic [63:0] RPC = 64'h0;
  localparam int          FC  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0, branch = 1'b0, to_branch = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] pc_out, pc_plus4;
  logic          if_id_flush, id_ex_flush, redirect_busy, misaligned;
`ifdef BRANCH_STATS_EN
  logic [31:0]   taken_count, resolved_count;
`endif

  pc_redirect_unit #(.ADDR_W(AW), .RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .to_branch(to_branch),
    .branch_target(branch_target), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .redirect_busy(redirect_busy), .misaligned(misaligned)
`ifdef BRANCH_STATS_EN
    , .taken_count(taken_count), .resolved_count(resolved_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic        fl;
    logic        mis;
    logic [31:0] tk;
    logic [31:0] rs;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Model state: remaining flush cycles, rather than a state machine.
  logic [63:0] m_pc  = RPC;
  int          m_left = 0;
  logic        m_mis = 1'b0;
  logic [31:0] m_tk  = '0, m_rs = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_left = 0; m_mis = 1'b0; m_tk = '0; m_rs = '0;
    q.delete();
  endtask

  // Advance the model by one clock edge, using the inputs as they were at that edge.
  task automatic model_edge();
    exp_t e;
    if (m_left == 0 && branch) m_rs = m_rs + 32'd1;
    if (m_left == 0 && branch && to_branch) begin
      m_tk   = m_tk + 32'd1;
      m_pc   = branch_target & ~64'h3;
      m_left = FC;
      m_mis  = (branch_target[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      if (!stall) m_pc = m_pc + 64'd4;
      if (m_left > 0) m_left--;
    end
    e.pc = m_pc; e.fl = (m_left > 0); e.mis = m_mis; e.tk = m_tk; e.rs = m_rs;
    q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 64'd1, 64'd0);
      return;
    end
    e = q.pop_front();
    chk("pc_out",        pc_out,         e.pc);
    chk("pc_plus4",      pc_plus4,       e.pc + 64'd4);
    chk("if_id_flush",   64'(if_id_flush),   64'(e.fl));
    chk("id_ex_flush",   64'(id_ex_flush),   64'(e.fl));
    chk("redirect_busy", 64'(redirect_busy), 64'(e.fl));
    chk("misaligned",    64'(misaligned),    64'(e.mis));
`ifdef BRANCH_STATS_EN
    chk("taken_count",    64'(taken_count),    64'(e.tk));
    chk("resolved_count", 64'(resolved_count), 64'(e.rs));
`endif
  endtask

  task automatic step(input logic s, input logic b, input logic t, input logic [63:0] tg);
    stall = s; branch = b; to_branch = t; branch_target = tg;
    @(posedge clk);
    model_edge();
    #1;
    check_out();
  endtask

  initial begin
    // Reset state, checked with no clock edge yet.
    #2;
    chk("rst_pc", pc_out, RPC);
    chk("rst_flush", 64'({if_id_flush, id_ex_flush, redirect_busy, misaligned}), 64'd0);
    @(negedge clk); reset = 1'b1;
    // Straight-line fetch: pc reads 4, 8, 12, 16 on the following edges.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 64'h0);
    chk("pc_at_0x10", pc_out, 64'h10);
    // Basic redirect, then 2 flush cycles.
    step(0, 1, 1, 64'h100);
    chk("redir_pc", pc_out, 64'h100);
    step(0, 0, 0, 64'h0);
    chk("flush_pc", pc_out, 64'h104);
    step(0, 0, 0, 64'h0);
    chk("flush_end", 64'(if_id_flush), 64'd0);
    // A redirect beats a stall, and a stall during FLUSH holds the PC.
    step(1, 1, 1, 64'h200);
    step(1, 0, 0, 64'h0);
    step(1, 0, 0, 64'h0);
    chk("stall_hold_pc", pc_out, 64'h200);
    step(0, 0, 0, 64'h0);
    // A branch during FLUSH is ignored; the first RUN cycle accepts one.
    step(0, 1, 1, 64'h280);
    step(0, 1, 1, 64'h300);
    step(0, 0, 0, 64'h0);
    step(0, 1, 1, 64'h300);
    chk("post_flush_redir", pc_out, 64'h300);
    step(0, 0, 0, 64'h0);
    step(0, 0, 0, 64'h0);
    // Not-taken branches and to_branch without branch.
    step(0, 1, 0, 64'h999);
    step(0, 0, 1, 64'h888);
    step(1, 1, 0, 64'h777);
    // A misaligned target raises misaligned for a single cycle.
    step(0, 1, 1, 64'h506);
    step(0, 0, 0, 64'h0);
    step(0, 0, 0, 64'h0);
`ifdef BRANCH_STATS_EN
    // Stats are checked here, before the reset below clears them.
    chk("stats_taken",    64'(taken_count),    64'(m_tk));
    chk("stats_resolved", 64'(resolved_count), 64'(m_rs));
`endif
    // Reset in the first FLUSH cycle takes effect immediately.
    step(0, 1, 1, 64'h402);
    chk("mis_pc", pc_out, 64'h400);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_pc", pc_out, RPC);
    chk("midrst_flags", 64'({if_id_flush, id_ex_flush, redirect_busy, misaligned}), 64'd0);
    @(negedge clk); reset = 1'b1;
    step(0, 0, 0, 64'h0);
    chk("post_rst_pc", pc_out, RPC + 64'd4);
    // The PC wraps modulo 2^64.
    step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_plus4", pc_plus4, 64'h0);
    step(0, 0, 0, 64'h0);
    chk("wrap_pc", pc_out, 64'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach end");
    $fatal(1, "timeout");
  end
endmodule
